// File: rtl/v2f_arith_combinator_model.sv
// Tick-accurate model of one Factorio arithmetic/decider combinator.
// Optional error tracking (err_sticky/err_count) under V2F_MODEL_ERR_STICKY_EN.
module v2f_arith_combinator_model #(
    parameter int DELAY = 1,
    parameter int OP_W  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    output logic [31:0]     y,
    output logic            out_valid,
`ifdef V2F_MODEL_ERR_STICKY_EN
    output logic            err_sticky,
    output logic [15:0]     err_count,
`endif
    output logic            div_zero
);

    typedef struct packed {
        logic [31:0] y;
        logic        v;
        logic        dz;
`ifdef V2F_MODEL_ERR_STICKY_EN
        logic        ovf;
`endif
    } stage_t;

    function automatic stage_t eval(input logic [OP_W-1:0] o,
                                    input logic signed [31:0] x,
                                    input logic signed [31:0] z);
        stage_t             r;
        logic signed [63:0] xe;
        logic signed [63:0] ze;
        logic signed [63:0] p;
        logic [31:0]        acc;
        logic [31:0]        base;
        r    = '0;
        r.v  = 1'b1;
        xe   = 64'(x);
        ze   = 64'(z);
        p    = xe * ze;
        acc  = 32'd1;
        base = x;
        case (int'(o))
            0: r.y = x + z;
            1: r.y = x - z;
            2: r.y = p[31:0];
            3: begin
                if (z == 0) r.dz = 1'b1;
                else if (x == 32'sh8000_0000 && z == -32'sd1) r.y = x;
                else r.y = x / z;
            end
            4: begin
                if (z == 0) r.dz = 1'b1;
                else if (z == -32'sd1) r.y = 32'd0;
                else r.y = x % z;
            end
            5: begin
                // square-and-multiply over the 31 magnitude bits of b
                for (int i = 0; i < 31; i++) begin
                    if (z[i]) acc = acc * base;
                    base = base * base;
                end
                r.y = z[31] ? 32'd0 : acc;
            end
            6:  r.y = x << z[4:0];
            7:  r.y = x >>> z[4:0];
            8:  r.y = x & z;
            9:  r.y = x | z;
            10: r.y = x ^ z;
            11: r.y = {31'd0, x > z};
            12: r.y = {31'd0, x < z};
            13: r.y = {31'd0, x >= z};
            14: r.y = {31'd0, x <= z};
            15: r.y = {31'd0, x == z};
            16: r.y = {31'd0, x != z};
            default: r.y = 32'd0;
        endcase
`ifdef V2F_MODEL_ERR_STICKY_EN
        case (int'(o))
            0: r.ovf = (x[31] == z[31]) && (r.y[31] != x[31]);
            1: r.ovf = (x[31] != z[31]) && (r.y[31] != x[31]);
            2: r.ovf = p[63:31] != {33{p[31]}};
            default: r.ovf = 1'b0;
        endcase
`endif
        return r;
    endfunction

    stage_t d_in [DELAY];
    stage_t q    [DELAY];

    always_comb begin
        d_in[0] = in_valid ? eval(op, a, b) : '0;
        for (int i = 1; i < DELAY; i++) begin
            d_in[i] = q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DELAY; i++) begin
            if (!rst_n) q[i] <= '0;
            else        q[i] <= d_in[i];
        end
    end

    assign y         = q[DELAY-1].y;
    assign out_valid = q[DELAY-1].v;
    assign div_zero  = q[DELAY-1].dz;

`ifdef V2F_MODEL_ERR_STICKY_EN
    // judged on the value entering the output stage so it lines up with y
    logic hit;
    assign hit = d_in[DELAY-1].v && (d_in[DELAY-1].dz || d_in[DELAY-1].ovf);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_count  <= 16'd0;
        end else if (hit) begin
            err_sticky <= 1'b1;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
